// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: keypad digit-entry buffer plus a time-multiplexed scan
// scheduler. It drives one shared 7-segment decoder and DIGITS active-low
// anodes. Every digit slot starts with a blanking gap to suppress ghosting.
module display_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_valid,
    input  logic [15:0]                   key_code,
    input  logic                          clr,
    output logic [15:0]                   dec_data,
    output logic                          dec_en,
    output logic [DIGITS-1:0]             an,
    output logic [$clog2(DIGITS+1)-1:0]   count,
    output logic                          full
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int CW = $clog2(DIGITS+1);

    localparam logic [DIGITS-1:0] AN_ONE = DIGITS'(1);

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_t;

    logic [15:0]       slot [DIGITS];
    logic [DIGITS-1:0] valid;
    logic [CW-1:0]     cnt_q;
    logic [PW-1:0]     pre;
    logic [IW-1:0]     idx;
    logic              code_onehot;
    logic              accept;
    phase_t            phase;

    // A key counts only if exactly one keypad line is active.
    assign code_onehot = (key_code != 16'd0) &&
                         ((key_code & (key_code - 16'd1)) == 16'd0);
    assign accept      = key_valid && !clr && (cnt_q < CW'(DIGITS)) && code_onehot;

    // The first BLANK cycles of every slot are dark. The rest of the slot drives the digit.
    assign phase = (pre < PW'(BLANK)) ? PH_BLANK : PH_DRIVE;

    assign count = cnt_q;
    assign full  = (cnt_q == CW'(DIGITS));

    // Entry buffer: an accepted key shifts in at slot 0. clr empties the buffer and takes priority over a key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the slot storage is reset along with the valid bits,
            // so a reset leaves no stale code visible on dec_data.
            for (int i = 0; i < DIGITS; i++) slot[i] <= 16'd0;
            valid <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            for (int i = 0; i < DIGITS; i++) slot[i] <= 16'd0;
            valid <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            // NOTE: non-blocking assignments make every slot read its
            // neighbour's old value, so the loop order does not matter.
            for (int i = DIGITS-1; i > 0; i--) slot[i] <= slot[i-1];
            slot[0] <= key_code;
            valid   <= {valid[DIGITS-2:0], 1'b1};
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    // Free-running scan prescaler and digit index. Key activity and clr do not affect them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PW'(SCAN_DIV-1)) begin
            pre <= '0;
            idx <= (idx == IW'(DIGITS-1)) ? '0 : idx + IW'(1);
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // Registered slot outputs: drive the selected digit in DRIVE only when its entry is valid. Stay dark otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an       <= '1;
            dec_en   <= 1'b0;
            dec_data <= 16'd0;
        end else begin
            an       <= '1;
            dec_en   <= 1'b0;
            dec_data <= 16'd0;
            case (phase)
                PH_DRIVE: begin
                    if (valid[idx]) begin
                        an       <= ~(AN_ONE << idx);
                        dec_en   <= 1'b1;
                        dec_data <= slot[idx];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with DIGITS=4, SCAN_DIV=8, BLANK=2.
// The model keeps the entries in a queue (newest at the front) and tracks
// the scan position by counting cycles since reset was released.
module tb_display_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 8;
    localparam int BLANK    = 2;

    typedef struct packed {
        logic [3:0]  an;
        logic        en;
        logic [15:0] data;
        logic [2:0]  count;
        logic        full;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [15:0] key_code;
    logic        clr;
    logic [15:0] dec_data;
    logic        dec_en;
    logic [3:0]  an;
    logic [2:0]  count;
    logic        full;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [15:0] model_q[$];
    exp_t        sb[$];
    logic [3:0]  last_an;

    display_scan_ctrl #(
        .DIGITS  (DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .BLANK   (BLANK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_valid(key_valid),
        .key_code (key_code),
        .clr      (clr),
        .dec_data (dec_data),
        .dec_en   (dec_en),
        .an       (an),
        .count    (count),
        .full     (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, and compare after the edge.
    task automatic tick(input logic kv, input logic [15:0] code, input logic c);
        exp_t e;
        int   p;
        int   i;
        key_valid = kv;
        key_code  = code;
        clr       = c;
        p = cyc % SCAN_DIV;
        i = (cyc / SCAN_DIV) % DIGITS;
        e = '0;
        e.an = 4'hF;
        if (p >= BLANK && i < model_q.size()) begin
            e.an[i] = 1'b0;
            e.en    = 1'b1;
            e.data  = model_q[i];
        end
        if (c)
            model_q.delete();
        else if (kv && model_q.size() < DIGITS && $countones(code) == 1)
            model_q.push_front(code);
        e.count = 3'(model_q.size());
        e.full  = (model_q.size() == DIGITS);
        sb.push_back(e);
        cyc++;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("display@%0d", cyc), {11'd0, an, dec_en, dec_data}, {11'd0, e.an, e.en, e.data});
        check($sformatf("count@%0d", cyc), {28'd0, count, full}, {28'd0, e.count, e.full});
        last_an = e.an;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 16'd0;
        clr       = 1'b0;
        last_an   = 4'hF;

        // Reset state while rst is held.
        repeat (3) @(posedge clk);
        #1;
        check("reset_an", {28'd0, an}, 32'h0000_000F);
        check("reset_en_data", {15'd0, dec_en, dec_data}, 32'd0);
        check("reset_count_full", {28'd0, count, full}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle scan: every digit stays dark.
        repeat (64) tick(1'b0, 16'd0, 1'b0);

        // Three entries, then two full refresh periods.
        tick(1'b1, 16'h0002, 1'b0);
        tick(1'b1, 16'h0004, 1'b0);
        tick(1'b1, 16'h0008, 1'b0);
        repeat (64) tick(1'b0, 16'd0, 1'b0);

        // Non-one-hot codes are dropped.
        tick(1'b1, 16'h0000, 1'b0);
        tick(1'b1, 16'h0011, 1'b0);
        repeat (32) tick(1'b0, 16'd0, 1'b0);

        // Overflow: the fourth press fills the buffer and the fifth is dropped.
        tick(1'b1, 16'h0010, 1'b0);
        tick(1'b1, 16'h0020, 1'b0);
        tick(1'b1, 16'h0020, 1'b0);
        repeat (40) tick(1'b0, 16'd0, 1'b0);

        // Clear priority over a same-cycle key, with two entries buffered.
        tick(1'b0, 16'd0, 1'b1);
        tick(1'b1, 16'h0040, 1'b0);
        tick(1'b1, 16'h0080, 1'b0);
        tick(1'b1, 16'h0001, 1'b1);
        repeat (40) tick(1'b0, 16'd0, 1'b0);

        // Reset asserted while digit 1 is being driven.
        tick(1'b1, 16'h0040, 1'b0);
        tick(1'b1, 16'h0080, 1'b0);
        for (int n = 0; n < 64 && last_an != 4'b1101; n++) tick(1'b0, 16'd0, 1'b0);
        check("reach_an_1101", {28'd0, last_an}, 32'h0000_000D);
        rst = 1'b1;
        #1;
        check("async_rst_an", {28'd0, an}, 32'h0000_000F);
        check("async_rst_en_data", {15'd0, dec_en, dec_data}, 32'd0);
        check("async_rst_count", {28'd0, count, full}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        sb.delete();
        cyc = 0;

        // After release the scan restarts at idx 0 and pre 0.
        tick(1'b1, 16'h0100, 1'b0);
        repeat (40) tick(1'b0, 16'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
